// File: rtl/blackjack_table.sv
// Blackjack table controller: deals from an external deck, sequences each seat's
// hit/stand decisions, plays the dealer hand and settles every seat against it.
module blackjack_table #(
    parameter int NUM_PLAYERS   = 2,
    parameter int DEALER_STAND  = 17,
    parameter bit HIT_SOFT17    = 1'b0,
    parameter int CHARLIE_CARDS = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [NUM_PLAYERS-1:0]   i_hit,
    input  logic [NUM_PLAYERS-1:0]   i_stand,
    input  logic                     i_cardValid,
    input  logic [3:0]               i_cardRank,
    output logic                     o_cardReq,
    output logic [3:0]               o_gameState,
    output logic [2:0]               o_activeSeat,
    output logic [5*NUM_PLAYERS-1:0] o_playerSum,
    output logic [4:0]               o_dealerSum,
    output logic [3:0]               o_dealerUpRank,
    output logic [2*NUM_PLAYERS-1:0] o_result,
    output logic                     o_roundDone
);
    localparam int         NS          = NUM_PLAYERS + 1;
    localparam int         DEALER_IDX  = NUM_PLAYERS;
    localparam logic [2:0] DEALER      = 3'(NUM_PLAYERS);
    localparam logic [2:0] NO_SEAT     = 3'd7;
    localparam logic [4:0] STAND_SUM   = 5'(DEALER_STAND);
    localparam logic [2:0] CHARLIE_CNT = 3'(CHARLIE_CARDS);
    localparam logic [1:0] R_PEND = 2'b00, R_WIN = 2'b01, R_LOSE = 2'b10, R_TIE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE            = 4'd0,
        S_DEAL            = 4'd1,
        S_CHECK_DEALER_BJ = 4'd2,
        S_PLAYER_CHOICE   = 4'd3,
        S_PLAYER_DRAW     = 4'd4,
        S_PLAYER_CHECK    = 4'd5,
        S_NEXT_SEAT       = 4'd6,
        S_DEALER_DRAW     = 4'd7,
        S_SETTLE          = 4'd8,
        S_DONE            = 4'd9
    } state_t;

    function automatic logic [4:0] card_value(input logic [3:0] rank);
        if (rank >= 4'd1 && rank <= 4'd10) begin
            card_value = {1'b0, rank};
        end else begin
            card_value = 5'd10;
        end
    endfunction

    function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
        logic [5:0] soft_sum;
        soft_sum = {1'b0, hard} + 6'd10;
        if (ace && soft_sum <= 6'd21) begin
            best_of = soft_sum[4:0];
        end else begin
            best_of = hard;
        end
    endfunction

    state_t     state_r, state_nx;
    logic [4:0] hard_r [NS];
    logic       ace_r  [NS];
    logic [2:0] cnt_r  [NS];
    logic [1:0] result_r [NUM_PLAYERS];
    logic [2:0] active_r, deal_seat_r;
    logic       deal_second_r, reveal_r, done_r;
    logic [3:0] up_rank_r;

    logic [4:0]    best_s [NS];
    logic [NS-1:0] bust_s, bj_s, charlie_s;
    logic          dealer_soft_s, dealer_hit_s;
    logic [4:0]    act_best_s;
    logic          act_bust_s, act_charlie_s, act_hit_s, act_stand_s;
    logic [2:0]    first_seat_s, next_seat_s, add_seat_s;
    logic          any_pend_s, card_req_s, consume_s, clear_s;

    // Per-seat hand evaluation and active-seat selection
    always_comb begin
        act_best_s    = 5'd0;
        act_bust_s    = 1'b0;
        act_charlie_s = 1'b0;
        act_hit_s     = 1'b0;
        act_stand_s   = 1'b0;
        first_seat_s  = NO_SEAT;
        next_seat_s   = NO_SEAT;
        any_pend_s    = 1'b0;
        for (int k = 0; k < NS; k++) begin
            best_s[k]    = best_of(hard_r[k], ace_r[k]);
            bust_s[k]    = best_s[k] > 5'd21;
            bj_s[k]      = (cnt_r[k] == 3'd2) && (best_s[k] == 5'd21);
            charlie_s[k] = (cnt_r[k] == CHARLIE_CNT) && !bust_s[k];
        end
        // Descending scan so the lowest qualifying seat wins
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            first_seat_s = !bj_s[k] ? 3'(k) : first_seat_s;
            next_seat_s  = (result_r[k] == R_PEND && 3'(k) > active_r) ? 3'(k) : next_seat_s;
            any_pend_s   = any_pend_s | (result_r[k] == R_PEND);
            act_best_s    = (active_r == 3'(k)) ? best_s[k] : act_best_s;
            act_bust_s    = act_bust_s    | ((active_r == 3'(k)) & bust_s[k]);
            act_charlie_s = act_charlie_s | ((active_r == 3'(k)) & charlie_s[k]);
            act_hit_s     = act_hit_s     | ((active_r == 3'(k)) & i_hit[k]);
            act_stand_s   = act_stand_s   | ((active_r == 3'(k)) & i_stand[k]);
        end
        dealer_soft_s = ace_r[DEALER_IDX] && (best_s[DEALER_IDX] != hard_r[DEALER_IDX]);
        dealer_hit_s  = !bust_s[DEALER_IDX] && !charlie_s[DEALER_IDX] &&
                        ((best_s[DEALER_IDX] < STAND_SUM) ||
                         (HIT_SOFT17 && dealer_soft_s && best_s[DEALER_IDX] == STAND_SUM));
    end

    // Game state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode, card request and card routing
    always_comb begin
        state_nx   = state_r;
        card_req_s = 1'b0;
        add_seat_s = DEALER;
        clear_s    = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                clear_s  = i_start;
                state_nx = i_start ? S_DEAL : state_r;
            end
            S_DEAL: begin
                card_req_s = 1'b1;
                add_seat_s = deal_seat_r;
                state_nx   = (i_cardValid && deal_second_r && deal_seat_r == DEALER) ?
                             S_CHECK_DEALER_BJ : S_DEAL;
            end
            S_CHECK_DEALER_BJ: begin
                if (bj_s[DEALER_IDX] || first_seat_s == NO_SEAT) begin
                    state_nx = S_SETTLE;
                end else begin
                    state_nx = S_PLAYER_CHOICE;
                end
            end
            S_PLAYER_CHOICE: begin
                if (act_stand_s) begin
                    state_nx = S_NEXT_SEAT;
                end else if (act_hit_s) begin
                    state_nx = S_PLAYER_DRAW;
                end else begin
                    state_nx = S_PLAYER_CHOICE;
                end
            end
            S_PLAYER_DRAW: begin
                card_req_s = 1'b1;
                add_seat_s = active_r;
                state_nx   = i_cardValid ? S_PLAYER_CHECK : S_PLAYER_DRAW;
            end
            S_PLAYER_CHECK: begin
                state_nx = (act_bust_s || act_charlie_s || act_best_s == 5'd21) ?
                           S_NEXT_SEAT : S_PLAYER_CHOICE;
            end
            S_NEXT_SEAT: begin
                if (next_seat_s != NO_SEAT) begin
                    state_nx = S_PLAYER_CHOICE;
                end else if (any_pend_s) begin
                    state_nx = S_DEALER_DRAW;
                end else begin
                    state_nx = S_SETTLE;
                end
            end
            S_DEALER_DRAW: begin
                card_req_s = dealer_hit_s;
                state_nx   = dealer_hit_s ? S_DEALER_DRAW : S_SETTLE;
            end
            S_SETTLE: state_nx = S_DONE;
            default:  state_nx = S_IDLE;
        endcase
        consume_s = card_req_s && i_cardValid;
    end

    // Hand accumulation for every seat including the dealer
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NS; k++) begin
                hard_r[k] <= 5'd0;
                ace_r[k]  <= 1'b0;
                cnt_r[k]  <= 3'd0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (clear_s) begin
                    hard_r[k] <= 5'd0;
                    ace_r[k]  <= 1'b0;
                    cnt_r[k]  <= 3'd0;
                end else if (consume_s && add_seat_s == 3'(k)) begin
                    hard_r[k] <= hard_r[k] + card_value(i_cardRank);
                    ace_r[k]  <= ace_r[k] | (i_cardRank == 4'd1);
                    cnt_r[k]  <= cnt_r[k] + 3'd1;
                end
            end
        end
    end

    // Round bookkeeping: deal pointer, active seat, reveal, results
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            active_r      <= NO_SEAT;
            deal_seat_r   <= 3'd0;
            deal_second_r <= 1'b0;
            up_rank_r     <= 4'd0;
            reveal_r      <= 1'b0;
            done_r        <= 1'b0;
            for (int k = 0; k < NUM_PLAYERS; k++) result_r[k] <= R_PEND;
        end else begin
            done_r <= (state_r == S_SETTLE);
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        active_r      <= NO_SEAT;
                        deal_seat_r   <= 3'd0;
                        deal_second_r <= 1'b0;
                        up_rank_r     <= 4'd0;
                        reveal_r      <= 1'b0;
                        for (int k = 0; k < NUM_PLAYERS; k++) result_r[k] <= R_PEND;
                    end
                end
                S_DEAL: begin
                    if (consume_s) begin
                        if (deal_seat_r == DEALER) begin
                            deal_seat_r   <= 3'd0;
                            deal_second_r <= 1'b1;
                            if (!deal_second_r) up_rank_r <= i_cardRank;
                        end else begin
                            deal_seat_r <= deal_seat_r + 3'd1;
                        end
                    end
                end
                S_CHECK_DEALER_BJ: begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        if (bj_s[DEALER_IDX]) begin
                            result_r[k] <= bj_s[k] ? R_TIE : R_LOSE;
                        end else begin
                            result_r[k] <= bj_s[k] ? R_WIN : R_PEND;
                        end
                    end
                    active_r <= bj_s[DEALER_IDX] ? NO_SEAT : first_seat_s;
                end
                S_PLAYER_CHECK: begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        if (active_r == 3'(k) && bust_s[k]) begin
                            result_r[k] <= R_LOSE;
                        end else if (active_r == 3'(k) && charlie_s[k]) begin
                            result_r[k] <= R_WIN;
                        end
                    end
                end
                S_NEXT_SEAT: begin
                    active_r <= next_seat_s;
                    if (next_seat_s == NO_SEAT && any_pend_s) reveal_r <= 1'b1;
                end
                S_SETTLE: begin
                    for (int k = 0; k < NUM_PLAYERS; k++) begin
                        if (result_r[k] == R_PEND) begin
                            if (bust_s[DEALER_IDX]) begin
                                result_r[k] <= R_WIN;
                            end else if (charlie_s[DEALER_IDX]) begin
                                result_r[k] <= R_LOSE;
                            end else if (best_s[k] > best_s[DEALER_IDX]) begin
                                result_r[k] <= R_WIN;
                            end else if (best_s[k] == best_s[DEALER_IDX]) begin
                                result_r[k] <= R_TIE;
                            end else begin
                                result_r[k] <= R_LOSE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output packing
    always_comb begin
        o_playerSum = '0;
        o_result    = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            o_playerSum[5*k +: 5] = best_s[k];
            o_result[2*k +: 2]    = result_r[k];
        end
    end

    assign o_cardReq      = card_req_s;
    assign o_gameState    = state_r;
    assign o_activeSeat   = active_r;
    assign o_dealerUpRank = up_rank_r;
    assign o_roundDone    = done_r;
    // Hole card stays hidden until the dealer starts playing
    assign o_dealerSum    = reveal_r ? best_s[DEALER_IDX] :
                            ((up_rank_r == 4'd0) ? 5'd0 : card_value(up_rank_r));
endmodule

// File: tb/tb_blackjack_table.sv
// Scoreboard bench for blackjack_table: two instances (dealer stands / hits on soft 17)
// share stimulus; per-round expectations are queued at start and checked on o_roundDone.
module tb_blackjack_table;
    localparam logic [3:0] S_IDLE = 4'd0, S_CHECK = 4'd2, S_CHOICE = 4'd3, S_NEXT = 4'd6;
    localparam logic [3:0] S_DDRAW = 4'd7, S_SETTLE = 4'd8, S_DONE = 4'd9;

    logic       clk = 1'b0;
    logic       rst, start, card_valid;
    logic [1:0] hit, stand;
    logic [3:0] card_rank;

    logic       card_req, h_card_req, round_done, h_round_done;
    logic [3:0] game_state, h_game_state, up_rank, h_up_rank, result, h_result;
    logic [2:0] active_seat, h_active_seat;
    logic [9:0] player_sum, h_player_sum;
    logic [4:0] dealer_sum, h_dealer_sum;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [9:0] psum;
        logic [3:0] res;
        logic [4:0] dsum;
    } exp_t;
    exp_t exp_q[$];
    exp_t exp_e;

    always #5 clk = ~clk;

    blackjack_table #(.NUM_PLAYERS(2), .DEALER_STAND(17), .HIT_SOFT17(1'b0), .CHARLIE_CARDS(5)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_hit(hit), .i_stand(stand),
        .i_cardValid(card_valid), .i_cardRank(card_rank), .o_cardReq(card_req),
        .o_gameState(game_state), .o_activeSeat(active_seat), .o_playerSum(player_sum),
        .o_dealerSum(dealer_sum), .o_dealerUpRank(up_rank), .o_result(result),
        .o_roundDone(round_done)
    );

    blackjack_table #(.NUM_PLAYERS(2), .DEALER_STAND(17), .HIT_SOFT17(1'b1), .CHARLIE_CARDS(5)) u_dut_h17 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_hit(hit), .i_stand(stand),
        .i_cardValid(card_valid), .i_cardRank(card_rank), .o_cardReq(h_card_req),
        .o_gameState(h_game_state), .o_activeSeat(h_active_seat), .o_playerSum(h_player_sum),
        .o_dealerSum(h_dealer_sum), .o_dealerUpRank(h_up_rank), .o_result(h_result),
        .o_roundDone(h_round_done)
    );

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Scoreboard: compare the round outcome when the round-done pulse appears
    always @(negedge clk) begin
        if (round_done) begin
            check_value("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                check_value("sb_player_sum", 32'(player_sum), 32'(exp_e.psum));
                check_value("sb_result", 32'(result), 32'(exp_e.res));
                check_value("sb_dealer_sum", 32'(dealer_sum), 32'(exp_e.dsum));
            end
        end
    end

    task automatic wait_state(input string tag, input logic [3:0] st);
        int n = 0;
        @(negedge clk);
        while (game_state != st && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (game_state != st) check_value(tag, 32'(game_state), 32'(st));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_round(input logic [9:0] psum, input logic [3:0] res, input logic [4:0] dsum);
        exp_t e;
        e.psum = psum;
        e.res  = res;
        e.dsum = dsum;
        exp_q.push_back(e);
        pulse_start();
    endtask

    task automatic give_card(input logic [3:0] rank);
        int n = 0;
        card_valid = 1'b1;
        card_rank  = rank;
        while (!card_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!card_req) begin
            check_value("card_req_wait", 32'(card_req), 32'd1);
        end else begin
            @(negedge clk);
        end
        card_valid = 1'b0;
    endtask

    task automatic deal(input logic [3:0] c0, c1, c2, c3, c4, c5);
        give_card(c0); give_card(c1); give_card(c2);
        give_card(c3); give_card(c4); give_card(c5);
    endtask

    task automatic pulse_seat(input logic [1:0] h, input logic [1:0] s);
        hit   = h;
        stand = s;
        @(negedge clk);
        hit   = 2'b00;
        stand = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_card_req"}, 32'(card_req), 32'd0);
        check_value({tag, "_state"}, 32'(game_state), 32'(S_IDLE));
        check_value({tag, "_active"}, 32'(active_seat), 32'd7);
        check_value({tag, "_psum"}, 32'(player_sum), 32'd0);
        check_value({tag, "_dsum"}, 32'(dealer_sum), 32'd0);
        check_value({tag, "_uprank"}, 32'(up_rank), 32'd0);
        check_value({tag, "_result"}, 32'(result), 32'd0);
        check_value({tag, "_done"}, 32'(round_done), 32'd0);
    endtask

    initial begin
        logic [3:0] hit_ranks [3];
        int n;
        hit_ranks = '{4'd2, 4'd3, 4'd4};
        rst = 1'b1; start = 1'b0; hit = 2'b00; stand = 2'b00;
        card_valid = 1'b0; card_rank = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Seat 0 blackjack, seat 1 stands on 17, dealer 5+6 draws a 10
        start_round({5'd17, 5'd21}, 4'b1001, 5'd21);
        deal(4'd10, 4'd9, 4'd5, 4'd1, 4'd8, 4'd6);
        wait_state("a_choice", S_CHOICE);
        check_value("a_active", 32'(active_seat), 32'd1);
        check_value("a_dsum_masked", 32'(dealer_sum), 32'd5);
        check_value("a_uprank", 32'(up_rank), 32'd5);
        check_value("a_seat0_bj", 32'(result[1:0]), 32'd1);
        check_value("a_psum", 32'(player_sum), 32'({5'd17, 5'd21}));
        pulse_seat(2'b00, 2'b10);
        wait_state("a_ddraw", S_DDRAW);
        check_value("a_dsum_reveal", 32'(dealer_sum), 32'd11);
        check_value("a_dealer_req", 32'(card_req), 32'd1);
        give_card(4'd10);
        wait_state("a_done", S_DONE);
        check_value("a_active_done", 32'(active_seat), 32'd7);

        // Dealer blackjack with hit held high the whole round
        hit = 2'b11;
        start_round({5'd16, 5'd21}, 4'b1011, 5'd1);
        deal(4'd1, 4'd9, 4'd1, 4'd12, 4'd7, 4'd13);
        check_value("b_check_state", 32'(game_state), 32'(S_CHECK));
        @(negedge clk);
        check_value("b_settle_state", 32'(game_state), 32'(S_SETTLE));
        wait_state("b_done", S_DONE);
        check_value("b_no_req", 32'(card_req), 32'd0);
        check_value("b_uprank", 32'(up_rank), 32'd1);
        hit = 2'b00;

        // Seat 0 five-card charlie, seat 1 hit+stand together takes the stand
        start_round({5'd18, 5'd14}, 4'b0101, 5'd17);
        deal(4'd2, 4'd10, 4'd10, 4'd3, 4'd8, 4'd7);
        for (int i = 0; i < 3; i++) begin
            wait_state("c_choice", S_CHOICE);
            check_value("c_active0", 32'(active_seat), 32'd0);
            pulse_seat(2'b01, 2'b00);
            give_card(hit_ranks[i]);
        end
        wait_state("c_choice1", S_CHOICE);
        check_value("c_active1", 32'(active_seat), 32'd1);
        check_value("c_charlie", 32'(result[1:0]), 32'd1);
        check_value("c_sum14", 32'(player_sum[4:0]), 32'd14);
        pulse_seat(2'b10, 2'b10);
        check_value("c_stand_wins", 32'(game_state), 32'(S_NEXT));
        wait_state("c_done", S_DONE);

        // Both seats bust: dealer never plays and stays masked
        start_round({5'd25, 5'd26}, 4'b1010, 5'd9);
        deal(4'd10, 4'd10, 4'd9, 4'd6, 4'd5, 4'd7);
        wait_state("f_choice0", S_CHOICE);
        pulse_seat(2'b01, 2'b00);
        give_card(4'd13);
        wait_state("f_choice1", S_CHOICE);
        check_value("f_active1", 32'(active_seat), 32'd1);
        check_value("f_bust0", 32'(result[1:0]), 32'd2);
        pulse_seat(2'b10, 2'b00);
        give_card(4'd12);
        wait_state("f_done", S_DONE);

        // Dealer soft 17: stands in one instance, hits in the other
        start_round({5'd17, 5'd18}, 4'b1101, 5'd17);
        deal(4'd10, 4'd10, 4'd1, 4'd8, 4'd7, 4'd6);
        wait_state("d_choice0", S_CHOICE);
        pulse_seat(2'b01, 2'b01);
        wait_state("d_choice1", S_CHOICE);
        pulse_seat(2'b10, 2'b10);
        wait_state("d_ddraw", S_DDRAW);
        check_value("d_s17_no_req", 32'(card_req), 32'd0);
        check_value("d_h17_req", 32'(h_card_req), 32'd1);
        check_value("d_h17_dsum", 32'(h_dealer_sum), 32'd17);
        card_valid = 1'b1;
        card_rank  = 4'd3;
        @(negedge clk);
        card_valid = 1'b0;
        n = 0;
        while (h_game_state != S_DONE && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("d_h17_done", 32'(h_game_state), 32'(S_DONE));
        check_value("d_h17_dsum20", 32'(h_dealer_sum), 32'd20);
        check_value("d_h17_result", 32'(h_result), 32'b1010);
        wait_state("d_done", S_DONE);

        // Reset while the dealer is requesting a card
        pulse_start();
        deal(4'd10, 4'd10, 4'd2, 4'd9, 4'd8, 4'd3);
        wait_state("e_choice0", S_CHOICE);
        pulse_seat(2'b01, 2'b01);
        wait_state("e_choice1", S_CHOICE);
        pulse_seat(2'b10, 2'b10);
        wait_state("e_ddraw", S_DDRAW);
        check_value("e_req_before", 32'(card_req), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("e_rst");
        check_value("e_h17_state", 32'(h_game_state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("e_idle_after", 32'(game_state), 32'(S_IDLE));

        check_value("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
